lsu_riscv: RTL and testbench
============================

Name: lsu_riscv

Overview:
- Multi-cycle load/store unit between the core datapath and a variable-latency data memory.
- Consumes the store operand (register-file port-2 read data) and the ALU-computed address.
- Produces the sign/zero-extended load result that the writeback path sends to the register-file write port.
- Performs byte-lane steering and alignment checks, and stalls the core until the memory handshake completes.

Parameters:
- TIMEOUT_CYCLES, 255, maximum BUSY cycles before abort; used only when LSU_TIMEOUT_EN is defined.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  synchronous reset, active-high.
- core_req_i  in  1  load/store request; held stable by the core while core_stall_o=1.
- core_we_i  in  1  1=store, 0=load.
- core_size_i  in  3  funct3: 0=B, 1=H, 2=W, 4=BU, 5=HU; 3/6/7 are illegal.
- core_addr_i  in  32  byte address.
- core_wd_i  in  32  store data (rs2).
- core_rd_o  out  32  extended load data; valid in DONE.
- core_stall_o  out  1  core must hold its state and inputs.
- lsu_exc_o  out  1  one-cycle pulse: misaligned access, illegal size, or timeout.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write enable.
- mem_be_o  out  4  byte enables.
- mem_addr_o  out  32  word-aligned address: {addr[31:2],2'b00}.
- mem_wd_o  out  32  lane-replicated store data.
- mem_rd_i  in  32  memory read word.
- mem_ready_i  in  1  memory completion; sampled only while mem_req_o=1.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous, active-high.
- Reset values: state=IDLE; mem_req_o=0, mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_wd_o=0; core_rd_o=0; lsu_exc_o=0.
- core_stall_o during reset = core_req_i (combinational; see formula below).
- States: IDLE, BUSY, DONE. Request fields are captured into registers on IDLE->BUSY and held until the next accept.

IDLE:
- core_req_i=1 with a legal, aligned access -> capture the request and go to BUSY.
- core_req_i=1 with a misaligned or illegal-size access -> no memory access; go to DONE, lsu_exc_o=1 in DONE, core_rd_o=0.
- Misaligned means: H/HU with addr[0]=1, or W with addr[1:0]!=0.

BUSY:
- mem_req_o=1 and all mem_* outputs are stable.
- mem_ready_i=1 -> latch the extended load result into core_rd_o (loads only) and go to DONE.
- For stores, core_rd_o holds its previous value.

DONE:
- core_stall_o=0 and mem_req_o=0; core_rd_o is valid for exactly this cycle. Next state is IDLE unconditionally.

Stall and latency:
- core_stall_o = (IDLE & core_req_i) | BUSY.
- Minimum latency: accept to DONE is 2 cycles (mem_ready_i high in the first BUSY cycle).

Byte enables and store data:
- B: be = 4'b0001 << addr[1:0]; wd = {4{wd[7:0]}}.
- H: be = addr[1] ? 4'b1100 : 4'b0011; wd = {2{wd[15:0]}}.
- W: be = 4'b1111; wd = wd.
- Loads also drive mem_be_o with the same pattern.

Load extraction:
- Select byte/half by addr[1:0].
- B/H are sign-extended from bit 7/15; BU/HU are zero-extended; W passes through.

Boundary conditions:
- mem_ready_i in IDLE or DONE: ignored.
- core_req_i deasserted mid-BUSY: the transaction still completes.
- Reset asserted in BUSY: IDLE on the next edge and mem_req_o drops; a late mem_ready_i is ignored.
- A back-to-back request is accepted in the IDLE cycle following DONE.

Optional Feature:
LSU_TIMEOUT_EN
- Defined:
  - An 8+-bit counter clears on entry to BUSY and increments each BUSY cycle without mem_ready_i.
  - On reaching TIMEOUT_CYCLES: abort (mem_req_o=0), go to DONE with lsu_exc_o=1 and core_rd_o=0.
  - mem_ready_i on the same cycle as the limit wins; the access completes normally, with no exception.
- Undefined:
  - No counter; BUSY waits indefinitely for mem_ready_i.
  - TIMEOUT_CYCLES is unused.

Test Plan:
1. Store: SB addr=0x103, wd=0xAABBCCDD, mem_ready_i on the 1st BUSY cycle -> mem_be_o=4'b1000, mem_wd_o=0xDDDDDDDD, mem_addr_o=0x100; core_stall_o high for 2 cycles, DONE on cycle 3.
2. Signed/unsigned loads: LH addr=0x202, mem_rd_i=0x8001_1234 -> core_rd_o=0xFFFF8001. LBU addr=0x201, same mem_rd_i -> core_rd_o=0x00000012.
3. Misalignment: LW addr=0x301 -> mem_req_o never asserts, lsu_exc_o=1 for one cycle, core_rd_o=0. Illegal size core_size_i=3 -> same response.
4. Wait states and reset: mem_ready_i delayed 5 cycles -> outputs stable throughout BUSY, stall for 6 cycles. Repeat with rst_i pulsed in the 3rd BUSY cycle -> IDLE next cycle, mem_req_o=0, a later mem_ready_i has no effect.
5. Timeout (LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4): mem_ready_i never asserts -> abort after 4 BUSY cycles, lsu_exc_o pulse. mem_ready_i on the 4th BUSY cycle -> normal completion, no exception.
6. Back-to-back: SW 0x400 then LW 0x400 with 1-cycle memory -> store completes, then the load is accepted in the following IDLE cycle, and core_rd_o returns the memory model's stored word.

Source files
------------

// File: rtl/lsu_riscv_if.sv
// Memory-side bus between the load/store unit and a variable-latency data memory.
// The LSU drives request, write enable, byte enables, word address and store data;
// the memory returns a read word and a completion strobe.
interface lsu_riscv_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  modport master (
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
    input  mem_rd_i, mem_ready_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
    output mem_rd_i, mem_ready_i
  );
endinterface

// File: rtl/lsu_riscv.sv
// Multi-cycle RISC-V load/store unit: byte-lane steering, alignment and size checks,
// sign/zero extension of load data, and core stall until the memory handshake ends.
// Optional feature macro: LSU_TIMEOUT_EN -- when defined, a BUSY cycle counter aborts
// an access that has not completed after TIMEOUT_CYCLES cycles.
module lsu_riscv #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        lsu_exc_o,
  lsu_riscv_if.master mem
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e      state_q, state_d;
  logic        accept, reject, complete, timeout, timeout_hit;
  logic        size_ok, misaligned;
  logic [3:0]  be_n;
  logic [31:0] wd_n;
  logic [31:0] load_ext;

  logic        we_q;
  logic [2:0]  size_q;
  logic [1:0]  off_q;
  logic [29:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wd_q;
  logic [31:0] rd_q;
  logic        exc_q;

  // A zero limit would make the abort compare wrap, so refuse it at elaboration
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("lsu_riscv: TIMEOUT_CYCLES must be at least 1");
  end

  // Decode request legality and build the lane-steered byte enables and store data
  always_comb begin
    size_ok    = (core_size_i == 3'd0) || (core_size_i == 3'd1) || (core_size_i == 3'd2) ||
                 (core_size_i == 3'd4) || (core_size_i == 3'd5);
    misaligned = (((core_size_i == 3'd1) || (core_size_i == 3'd5)) && core_addr_i[0]) ||
                 ((core_size_i == 3'd2) && (core_addr_i[1:0] != 2'b00));
    be_n = 4'b1111;
    wd_n = core_wd_i;
    case (core_size_i)
      3'd0, 3'd4: begin
        be_n = 4'b0001 << core_addr_i[1:0];
        wd_n = {4{core_wd_i[7:0]}};
      end
      3'd1, 3'd5: begin
        be_n = core_addr_i[1] ? 4'b1100 : 4'b0011;
        wd_n = {2{core_wd_i[15:0]}};
      end
      default: begin
        be_n = 4'b1111;
        wd_n = core_wd_i;
      end
    endcase
  end

  // Pick the addressed byte/half from the memory word and extend it per the captured size
  always_comb begin
    logic [7:0]  lb;
    logic [15:0] lh;
    lb = mem.mem_rd_i[7:0];
    case (off_q)
      2'd0: lb = mem.mem_rd_i[7:0];
      2'd1: lb = mem.mem_rd_i[15:8];
      2'd2: lb = mem.mem_rd_i[23:16];
      default: lb = mem.mem_rd_i[31:24];
    endcase
    lh = off_q[1] ? mem.mem_rd_i[31:16] : mem.mem_rd_i[15:0];
    case (size_q)
      3'd0:    load_ext = {{24{lb[7]}}, lb};
      3'd1:    load_ext = {{16{lh[15]}}, lh};
      3'd4:    load_ext = {24'd0, lb};
      3'd5:    load_ext = {16'd0, lh};
      default: load_ext = mem.mem_rd_i;
    endcase
  end

  // Next-state logic; a completion in the same cycle as the limit beats the abort
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    reject   = 1'b0;
    complete = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      IDLE: begin
        if (core_req_i) begin
          if (size_ok && !misaligned) begin
            accept  = 1'b1;
            state_d = BUSY;
          end else begin
            reject  = 1'b1;
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        if (mem.mem_ready_i) begin
          complete = 1'b1;
          state_d  = DONE;
        end else if (timeout_hit) begin
          timeout = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, captured request fields and the DONE-cycle result/exception
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 3'd0;
      off_q   <= 2'd0;
      addr_q  <= 30'd0;
      be_q    <= 4'd0;
      wd_q    <= 32'd0;
      rd_q    <= 32'd0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      exc_q   <= reject | timeout;
      if (accept) begin
        we_q   <= core_we_i;
        size_q <= core_size_i;
        off_q  <= core_addr_i[1:0];
        addr_q <= core_addr_i[31:2];
        be_q   <= be_n;
        wd_q   <= wd_n;
      end
      if (reject || timeout) begin
        rd_q <= 32'd0;
      end else if (complete && !we_q) begin
        rd_q <= load_ext;
      end
    end
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] cnt_q;

  // Count BUSY cycles without completion; restart on every accepted request
  always_ff @(posedge clk_i) begin
    if (rst_i || accept) begin
      cnt_q <= '0;
    end else if ((state_q == BUSY) && !mem.mem_ready_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign timeout_hit = (state_q == BUSY) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  assign mem.mem_req_o  = (state_q == BUSY);
  assign mem.mem_we_o   = we_q;
  assign mem.mem_be_o   = be_q;
  assign mem.mem_addr_o = {addr_q, 2'b00};
  assign mem.mem_wd_o   = wd_q;

  assign core_rd_o    = rd_q;
  assign lsu_exc_o    = exc_q;
  assign core_stall_o = ((state_q == IDLE) && core_req_i) || (state_q == BUSY);

endmodule

// File: tb/tb_lsu_riscv.sv
// Self-checking bench for lsu_riscv: a table of single-access vectors with a
// one-cycle memory, plus directed sequences for wait states, reset mid-access,
// back-to-back requests and (when LSU_TIMEOUT_EN is defined) the timeout abort.
module tb_lsu_riscv;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned TO_CYC = 4;
`else
  localparam int unsigned TO_CYC = 255;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        lsu_exc_o;

  int checks = 0;
  int errors = 0;

  lsu_riscv_if mem_if ();

  lsu_riscv #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .core_req_i   (core_req_i),
    .core_we_i    (core_we_i),
    .core_size_i  (core_size_i),
    .core_addr_i  (core_addr_i),
    .core_wd_i    (core_wd_i),
    .core_rd_o    (core_rd_o),
    .core_stall_o (core_stall_o),
    .lsu_exc_o    (lsu_exc_o),
    .mem          (mem_if)
  );

  // Free-running 10 ns clock
  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    logic        exc;
    logic [3:0]  be;
    logic [31:0] mwd;
    logic [31:0] maddr;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(string name, logic we, logic [2:0] size, logic [31:0] addr,
                              logic [31:0] wd, logic [31:0] rdata, logic exc, logic [3:0] be,
                              logic [31:0] mwd, logic [31:0] maddr, logic [31:0] rd);
    vec_t v;
    v.name = name; v.we = we; v.size = size; v.addr = addr; v.wd = wd; v.rdata = rdata;
    v.exc = exc; v.be = be; v.mwd = mwd; v.maddr = maddr; v.rd = rd;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic driveReq(input logic we, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wd);
    core_req_i  = 1'b1;
    core_we_i   = we;
    core_size_i = size;
    core_addr_i = addr;
    core_wd_i   = wd;
  endtask

  // One complete access from the IDLE cycle back to the next IDLE cycle
  task automatic applyStimulus(input vec_t v);
    driveReq(v.we, v.size, v.addr, v.wd);
    mem_if.mem_ready_i = 1'b0;
    mem_if.mem_rd_i    = v.rdata;
    #1;
    checkOutput({v.name, " stall_idle"}, 32'(core_stall_o), 32'd1);
    checkOutput({v.name, " req_idle"}, 32'(mem_if.mem_req_o), 32'd0);
    tick();
    if (v.exc) begin
      checkOutput({v.name, " req_done"}, 32'(mem_if.mem_req_o), 32'd0);
      checkOutput({v.name, " exc_done"}, 32'(lsu_exc_o), 32'd1);
      checkOutput({v.name, " rd_done"}, core_rd_o, 32'd0);
      checkOutput({v.name, " stall_done"}, 32'(core_stall_o), 32'd0);
      core_req_i = 1'b0;
      tick();
      checkOutput({v.name, " exc_pulse_end"}, 32'(lsu_exc_o), 32'd0);
    end else begin
      checkOutput({v.name, " req_busy"}, 32'(mem_if.mem_req_o), 32'd1);
      checkOutput({v.name, " we"}, 32'(mem_if.mem_we_o), 32'(v.we));
      checkOutput({v.name, " be"}, 32'(mem_if.mem_be_o), 32'(v.be));
      checkOutput({v.name, " wd"}, mem_if.mem_wd_o, v.mwd);
      checkOutput({v.name, " addr"}, mem_if.mem_addr_o, v.maddr);
      checkOutput({v.name, " stall_busy"}, 32'(core_stall_o), 32'd1);
      mem_if.mem_ready_i = 1'b1;
      tick();
      mem_if.mem_ready_i = 1'b0;
      core_req_i = 1'b0;
      checkOutput({v.name, " stall_done"}, 32'(core_stall_o), 32'd0);
      checkOutput({v.name, " req_done"}, 32'(mem_if.mem_req_o), 32'd0);
      checkOutput({v.name, " exc_done"}, 32'(lsu_exc_o), 32'd0);
      if (!v.we) checkOutput({v.name, " rd"}, core_rd_o, v.rd);
      tick();
    end
  endtask

  initial begin
    int stall_cnt;
    logic [31:0] model_word;

    vecs[0]  = mk("SB_103",  1'b1, 3'd0, 32'h103, 32'hAABBCCDD, 32'h0,        1'b0, 4'b1000, 32'hDDDDDDDD, 32'h100, 32'h0);
    vecs[1]  = mk("LH_202",  1'b0, 3'd1, 32'h202, 32'h0,        32'h80011234, 1'b0, 4'b1100, 32'h0,        32'h200, 32'hFFFF8001);
    vecs[2]  = mk("LBU_201", 1'b0, 3'd4, 32'h201, 32'h0,        32'h80011234, 1'b0, 4'b0010, 32'h0,        32'h200, 32'h00000012);
    vecs[3]  = mk("LB_203",  1'b0, 3'd0, 32'h203, 32'h0,        32'h80011234, 1'b0, 4'b1000, 32'h0,        32'h200, 32'hFFFFFF80);
    vecs[4]  = mk("LHU_202", 1'b0, 3'd5, 32'h202, 32'h0,        32'h80011234, 1'b0, 4'b1100, 32'h0,        32'h200, 32'h00008001);
    vecs[5]  = mk("LW_204",  1'b0, 3'd2, 32'h204, 32'h0,        32'hDEADBEEF, 1'b0, 4'b1111, 32'h0,        32'h204, 32'hDEADBEEF);
    vecs[6]  = mk("SH_102",  1'b1, 3'd1, 32'h102, 32'h12345678, 32'h0,        1'b0, 4'b1100, 32'h56785678, 32'h100, 32'h0);
    vecs[7]  = mk("SW_108",  1'b1, 3'd2, 32'h108, 32'hCAFEF00D, 32'h0,        1'b0, 4'b1111, 32'hCAFEF00D, 32'h108, 32'h0);
    vecs[8]  = mk("LW_301",  1'b0, 3'd2, 32'h301, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0,   32'h0);
    vecs[9]  = mk("SIZE3",   1'b0, 3'd3, 32'h300, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0,   32'h0);
    vecs[10] = mk("LH_203",  1'b0, 3'd1, 32'h203, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0,   32'h0);
    vecs[11] = mk("SIZE7",   1'b1, 3'd7, 32'h300, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0,   32'h0);
    vecs[12] = mk("LB_200",  1'b0, 3'd0, 32'h200, 32'h0,        32'h0000007F, 1'b0, 4'b0001, 32'h0,        32'h200, 32'h0000007F);
    vecs[13] = mk("SB_101",  1'b1, 3'd0, 32'h101, 32'h000000A5, 32'h0,        1'b0, 4'b0010, 32'hA5A5A5A5, 32'h100, 32'h0);

    // Reset with a pending request: state held in IDLE, stall follows core_req_i
    rst_i = 1'b1;
    driveReq(1'b0, 3'd2, 32'h0, 32'h0);
    mem_if.mem_ready_i = 1'b0;
    mem_if.mem_rd_i    = 32'h0;
    tick();
    tick();
    checkOutput("rst stall_req", 32'(core_stall_o), 32'd1);
    checkOutput("rst mem_req", 32'(mem_if.mem_req_o), 32'd0);
    checkOutput("rst mem_we", 32'(mem_if.mem_we_o), 32'd0);
    checkOutput("rst mem_be", 32'(mem_if.mem_be_o), 32'd0);
    checkOutput("rst mem_addr", mem_if.mem_addr_o, 32'd0);
    checkOutput("rst mem_wd", mem_if.mem_wd_o, 32'd0);
    checkOutput("rst core_rd", core_rd_o, 32'd0);
    checkOutput("rst exc", 32'(lsu_exc_o), 32'd0);
    core_req_i = 1'b0;
    #1;
    checkOutput("rst stall_noreq", 32'(core_stall_o), 32'd0);
    tick();
    rst_i = 1'b0;

    // Stray mem_ready_i while IDLE must not start anything
    mem_if.mem_ready_i = 1'b1;
    tick();
    mem_if.mem_ready_i = 1'b0;
    checkOutput("idle_ready mem_req", 32'(mem_if.mem_req_o), 32'd0);
    checkOutput("idle_ready stall", 32'(core_stall_o), 32'd0);
    checkOutput("idle_ready exc", 32'(lsu_exc_o), 32'd0);

    $display("[TB] table vectors");
    for (int i = 0; i < 14; i++) applyStimulus(vecs[i]);

    // Wait states: ready in the 5th BUSY cycle, request dropped mid-access
    $display("[TB] wait-state sequence");
    stall_cnt = 0;
    driveReq(1'b0, 3'd2, 32'h208, 32'h0);
    mem_if.mem_rd_i = 32'h0BADF00D;
    #1;
    if (core_stall_o) stall_cnt++;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (core_stall_o) stall_cnt++;
      checkOutput($sformatf("ws req_b%0d", k), 32'(mem_if.mem_req_o), 32'd1);
      checkOutput($sformatf("ws addr_b%0d", k), mem_if.mem_addr_o, 32'h208);
      checkOutput($sformatf("ws be_b%0d", k), 32'(mem_if.mem_be_o), 32'hF);
      checkOutput($sformatf("ws we_b%0d", k), 32'(mem_if.mem_we_o), 32'd0);
      if (k == 2) core_req_i = 1'b0;
      if (k == 5) mem_if.mem_ready_i = 1'b1;
    end
    tick();
    mem_if.mem_ready_i = 1'b0;
    checkOutput("ws stall_cycles", 32'(stall_cnt), 32'd6);
    checkOutput("ws stall_done", 32'(core_stall_o), 32'd0);
    checkOutput("ws rd", core_rd_o, 32'h0BADF00D);
    tick();

    // Reset in the 3rd BUSY cycle; a late ready afterwards is ignored
    $display("[TB] reset-in-busy sequence");
    driveReq(1'b1, 3'd2, 32'h20C, 32'h11223344);
    tick();
    checkOutput("rb req_b1", 32'(mem_if.mem_req_o), 32'd1);
    tick();
    checkOutput("rb req_b2", 32'(mem_if.mem_req_o), 32'd1);
    core_req_i = 1'b0;
    tick();
    checkOutput("rb req_b3", 32'(mem_if.mem_req_o), 32'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    checkOutput("rb req_after_rst", 32'(mem_if.mem_req_o), 32'd0);
    checkOutput("rb addr_after_rst", mem_if.mem_addr_o, 32'd0);
    checkOutput("rb stall_after_rst", 32'(core_stall_o), 32'd0);
    mem_if.mem_ready_i = 1'b1;
    tick();
    mem_if.mem_ready_i = 1'b0;
    checkOutput("rb late_ready req", 32'(mem_if.mem_req_o), 32'd0);
    checkOutput("rb late_ready exc", 32'(lsu_exc_o), 32'd0);
    checkOutput("rb late_ready stall", 32'(core_stall_o), 32'd0);
    tick();

    // Back-to-back SW then LW to the same word through a one-word memory model
    $display("[TB] back-to-back sequence");
    model_word = 32'h0;
    driveReq(1'b1, 3'd2, 32'h400, 32'h13579BDF);
    tick();
    checkOutput("b2b st_req", 32'(mem_if.mem_req_o), 32'd1);
    checkOutput("b2b st_we", 32'(mem_if.mem_we_o), 32'd1);
    checkOutput("b2b st_addr", mem_if.mem_addr_o, 32'h400);
    if (mem_if.mem_we_o && (mem_if.mem_be_o == 4'hF)) model_word = mem_if.mem_wd_o;
    mem_if.mem_ready_i = 1'b1;
    tick();
    mem_if.mem_ready_i = 1'b0;
    checkOutput("b2b st_done_stall", 32'(core_stall_o), 32'd0);
    driveReq(1'b0, 3'd2, 32'h400, 32'h0);
    tick();
    checkOutput("b2b ld_idle_stall", 32'(core_stall_o), 32'd1);
    checkOutput("b2b ld_idle_req", 32'(mem_if.mem_req_o), 32'd0);
    tick();
    checkOutput("b2b ld_req", 32'(mem_if.mem_req_o), 32'd1);
    checkOutput("b2b ld_we", 32'(mem_if.mem_we_o), 32'd0);
    mem_if.mem_rd_i    = model_word;
    mem_if.mem_ready_i = 1'b1;
    tick();
    mem_if.mem_ready_i = 1'b0;
    core_req_i = 1'b0;
    checkOutput("b2b ld_rd", core_rd_o, 32'h13579BDF);
    tick();

`ifdef LSU_TIMEOUT_EN
    // Timeout: no ready at all aborts after TO_CYC BUSY cycles
    $display("[TB] timeout sequence");
    driveReq(1'b0, 3'd2, 32'h500, 32'h0);
    mem_if.mem_rd_i = 32'h77777777;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checkOutput($sformatf("to req_b%0d", k), 32'(mem_if.mem_req_o), 32'd1);
      checkOutput($sformatf("to exc_b%0d", k), 32'(lsu_exc_o), 32'd0);
    end
    tick();
    checkOutput("to abort_exc", 32'(lsu_exc_o), 32'd1);
    checkOutput("to abort_req", 32'(mem_if.mem_req_o), 32'd0);
    checkOutput("to abort_rd", core_rd_o, 32'd0);
    checkOutput("to abort_stall", 32'(core_stall_o), 32'd0);
    core_req_i = 1'b0;
    tick();
    checkOutput("to exc_pulse_end", 32'(lsu_exc_o), 32'd0);

    // Ready on the limit cycle wins over the abort
    driveReq(1'b0, 3'd2, 32'h504, 32'h0);
    mem_if.mem_rd_i = 32'h55AA55AA;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checkOutput($sformatf("tw req_b%0d", k), 32'(mem_if.mem_req_o), 32'd1);
      if (k == 4) mem_if.mem_ready_i = 1'b1;
    end
    tick();
    mem_if.mem_ready_i = 1'b0;
    core_req_i = 1'b0;
    checkOutput("tw exc", 32'(lsu_exc_o), 32'd0);
    checkOutput("tw rd", core_rd_o, 32'h55AA55AA);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
